// File: rtl/shared_ram_arb_pkg.sv
// Shared constants and helpers for the shared-RAM arbiter.
package shared_ram_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational one-hot grant picker: fixed priority with forced override, or round-robin from ptr.
// Zero latency; no state.
module arb_select #(
  parameter int NPORTS = 2,
  parameter int PW     = 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic              mode,
  input  logic [PW-1:0]     ptr,
  input  logic [NPORTS-1:0] forced,
  output logic [NPORTS-1:0] gnt
);

  int idx;

  // Scans run from the far end so the last hit, i.e. the highest-priority one, wins.
  always_comb begin
    gnt = '0;
    idx = 0;
    if (mode) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % NPORTS;
        if (req[idx]) gnt = NPORTS'(1) << idx;
      end
    end else if (|forced) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (forced[i]) gnt = NPORTS'(1) << i;
      end
    end else begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (req[i]) gnt = NPORTS'(1) << i;
      end
    end
  end

endmodule

// File: rtl/shared_ram_arb.sv
// N-port arbiter in front of one single-port synchronous RAM with byte-lane steering for 8-bit masters.
// Grant and RAM access are same-cycle; read data returns exactly one cycle later and never stalls.
module shared_ram_arb
  import shared_ram_arb_pkg::*;
#(
  parameter int          NPORTS     = 2,
  parameter int          AW         = 10,
  parameter int          DW         = 32,
  parameter int          MODE       = MODE_FIXED,
  parameter int          MAX_WAIT   = 15,
  parameter int unsigned BYTE_PORTS = 'b01,
  localparam int         NB         = DW / 8,
  localparam int         LB         = clog2(NB),
  localparam int         RAW        = AW - LB
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    i_req,
  input  logic [NPORTS-1:0]    i_we,
  input  logic [NPORTS*AW-1:0] i_addr,
  input  logic [NPORTS*DW-1:0] i_wdata,
  input  logic [NPORTS*NB-1:0] i_wstrb,
  output logic [NPORTS-1:0]    o_gnt,
  output logic [NPORTS-1:0]    o_rvalid,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_ram_ce,
  output logic [RAW-1:0]       o_ram_addr,
  output logic [DW-1:0]        o_ram_wdata,
  output logic [NB-1:0]        o_ram_we,
  input  logic [DW-1:0]        i_ram_rdata
);

  localparam int          PW = (NPORTS > 1) ? clog2(NPORTS) : 1;
  localparam int          CW = (MAX_WAIT > 0) ? clog2(MAX_WAIT + 1) : 1;
  localparam int          LW = (LB > 0) ? LB : 1;
  localparam logic [31:0] BP = 32'(BYTE_PORTS);

  if (NPORTS < 1 || DW % 8 != 0) begin : g_bad_cfg
    $fatal(1, "shared_ram_arb: NPORTS must be >= 1 and DW a multiple of 8");
  end

  logic [RAW-1:0]    p_waddr [NPORTS];
  logic [LW-1:0]     p_lane  [NPORTS];
  logic [DW-1:0]     p_wdata [NPORTS];
  logic [NB-1:0]     p_we    [NPORTS];
  logic [CW-1:0]     wait_cnt[NPORTS];
  logic [NPORTS-1:0] forced;
  logic [NPORTS-1:0] gnt;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx;
  logic [LW-1:0]     gnt_lane;
  logic              gnt_rd;
  logic              gnt_byte;
  logic              rd_pend;
  logic              tag_byte;
  logic [PW-1:0]     tag_port;
  logic [LW-1:0]     tag_lane;
  logic              unused_ok;

  // Byte ports ignore their strobes and upper write-data bits.
  assign unused_ok = ^{i_wstrb, i_wdata};

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [AW-1:0] addr;
    assign addr       = i_addr[p*AW +: AW];
    assign p_waddr[p] = addr[AW-1:LB];
    if (LB > 0) begin : g_lane
      assign p_lane[p] = addr[LW-1:0];
    end else begin : g_nolane
      assign p_lane[p] = '0;
    end
    if (BP[p]) begin : g_byte
      assign p_wdata[p] = {NB{i_wdata[p*DW +: 8]}};
      assign p_we[p]    = i_we[p] ? (NB'(1) << p_lane[p]) : '0;
    end else begin : g_word
      assign p_wdata[p] = i_wdata[p*DW +: DW];
      assign p_we[p]    = i_wstrb[p*NB +: NB] & {NB{i_we[p]}};
    end
    assign forced[p] = (MODE == MODE_FIXED) && (MAX_WAIT > 0) && i_req[p]
                       && (wait_cnt[p] == CW'(MAX_WAIT));
  end

  arb_select #(.NPORTS(NPORTS), .PW(PW)) u_sel (
    .req   (i_req),
    .mode  (MODE == MODE_RR),
    .ptr   (rr_ptr),
    .forced(forced),
    .gnt   (gnt)
  );

  assign o_gnt = gnt;

  always_comb begin
    o_ram_ce    = |gnt;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_ram_we    = '0;
    gnt_idx     = '0;
    gnt_lane    = '0;
    gnt_rd      = 1'b0;
    gnt_byte    = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt[p]) begin
        o_ram_addr  = p_waddr[p];
        o_ram_wdata = p_wdata[p];
        o_ram_we    = p_we[p];
        gnt_idx     = PW'(p);
        gnt_lane    = p_lane[p];
        gnt_rd      = !i_we[p];
        gnt_byte    = BP[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      rd_pend  <= 1'b0;
      tag_port <= '0;
      tag_lane <= '0;
      tag_byte <= 1'b0;
      for (int p = 0; p < NPORTS; p++) wait_cnt[p] <= '0;
    end else begin
      if (|gnt) rr_ptr <= (gnt_idx == PW'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
      rd_pend <= gnt_rd;
      if (gnt_rd) begin
        tag_port <= gnt_idx;
        tag_lane <= gnt_lane;
        tag_byte <= gnt_byte;
      end
      // Saturating refusal count; the escape fires once it reaches MAX_WAIT.
      for (int p = 0; p < NPORTS; p++) begin
        if (!i_req[p] || gnt[p]) begin
          wait_cnt[p] <= '0;
        end else if (MODE == MODE_FIXED && wait_cnt[p] != CW'(MAX_WAIT)) begin
          wait_cnt[p] <= wait_cnt[p] + 1'b1;
        end
      end
    end
  end

  // Read data comes straight off the RAM's output register, steered by the stored tag.
  always_comb begin
    o_rvalid = '0;
    o_rdata  = '0;
    if (rd_pend && !rst) begin
      o_rvalid[tag_port] = 1'b1;
      o_rdata = tag_byte ? DW'(i_ram_rdata[{tag_lane, 3'b000} +: 8]) : i_ram_rdata;
    end
  end

endmodule
